// File: rtl/text_layer.sv
// rtl/text_layer.sv - character-cell text overlay with a run-time written tile buffer
// Optional build macro: TEXT_LAYER_HIT_EN adds the registered text_hit overlay mask output.
module text_layer #(
  parameter int COLS         = 28,
  parameter int ROWS         = 36,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [7:0]              wr_char,
  input  logic [2:0]              wr_attr,
  input  logic                    clear,
  output logic                    busy,
  input  logic                    frame_start,
  input  logic [7:0]              sx,
  input  logic [8:0]              sy,
  output logic [3:0]              R,
  output logic [3:0]              G,
  output logic [3:0]              B
`ifdef TEXT_LAYER_HIT_EN
  ,
  output logic                    text_hit
`endif
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;

  logic [10:0]     mem [0:CELLS-1];
  logic            ram_we;
  logic [AW-1:0]   ram_wa;
  logic [10:0]     ram_wd;
  logic [AW-1:0]   host_addr;
  logic            host_in_range;

  logic [AW-1:0]   rd_addr;
  logic            in_area;
  logic [10:0]     rd_q;
  logic [2:0]      fx_q, fy_q;
  logic            in_area_q;

  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;

  logic [7:0]      glyph_row;
  logic            font_bit;
  logic            lit;
  logic [11:0]     pix_rgb;

  // Subset of the shared 8x8 font; codes without a glyph render as an outline box.
  function automatic logic [7:0] font_row(input logic [7:0] ch, input logic [2:0] r);
    logic [63:0] g;
    logic [2:0]  idx;
    case (ch)
      8'h20:   g = 64'h0000_0000_0000_0000;
      8'h23:   g = 64'h2424_7E24_7E24_2400;
      8'h41:   g = 64'h1824_4242_7E42_4200;
      8'h5A:   g = 64'h7E04_0810_2040_7E00;
      default: g = 64'h7E42_4242_4242_7E00;
    endcase
    idx = 3'd7 - r;
    return g[{idx, 3'b000} +: 8];
  endfunction

  assign host_addr     = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
  assign host_in_range = ({1'b0, wr_col} < (CW + 1)'(COLS)) && ({1'b0, wr_row} < (RW + 1)'(ROWS));
  assign in_area       = ({1'b0, sx} < 9'(COLS * 8)) && ({1'b0, sy} < 10'(ROWS * 8));
  assign rd_addr       = in_area ? (AW'(sy[8:3]) * AW'(COLS) + AW'(sx[7:3])) : '0;

  // Clear FSM state register; reset restarts the fill from cell 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic and handshake outputs; clear beats a same-cycle write.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    busy     = (state_q == S_CLEAR);
    wr_ready = (state_q == S_IDLE) && !clear;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          addr_d  = '0;
        end
      end
      S_CLEAR: begin
        if (addr_q == AW'(CELLS - 1)) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single write port: the fill owns it while clearing, otherwise accepted in-range host writes.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = host_addr;
    ram_wd = {wr_char, wr_attr};
    if (state_q == S_CLEAR) begin
      ram_we = 1'b1;
      ram_wa = addr_q;
      ram_wd = {8'h20, 3'b000};
    end else if (wr_valid && wr_ready && host_in_range) begin
      ram_we = 1'b1;
    end
  end

  // Tile RAM, read-first: a same-cycle write to the rendered cell returns the old cell.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_wa] <= ram_wd;
    end
    rd_q <= mem[rd_addr];
  end

  // Stage 1 side-band: glyph-relative pixel position and in-area flag travel with the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      fx_q      <= '0;
      fy_q      <= '0;
      in_area_q <= 1'b0;
    end else begin
      fx_q      <= sx[2:0];
      fy_q      <= sy[2:0];
      in_area_q <= in_area;
    end
  end

  // Blink timer: advances once per frame, flips phase every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Stage 2 combinational: glyph pixel, blink masking and colour selection.
  always_comb begin
    glyph_row = font_row(rd_q[10:3], fy_q);
    font_bit  = glyph_row[3'd7 - fx_q];
    lit       = in_area_q && font_bit && !(rd_q[2] && !blink_phase);
    pix_rgb   = 12'h000;
    if (lit) begin
      case (rd_q[1:0])
        2'd0:    pix_rgb = 12'hFFF;
        2'd1:    pix_rgb = 12'hFF0;
        2'd2:    pix_rgb = 12'hF00;
        default: pix_rgb = 12'h0FF;
      endcase
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      R <= '0;
      G <= '0;
      B <= '0;
`ifdef TEXT_LAYER_HIT_EN
      text_hit <= 1'b0;
`endif
    end else begin
      R <= pix_rgb[11:8];
      G <= pix_rgb[7:4];
      B <= pix_rgb[3:0];
`ifdef TEXT_LAYER_HIT_EN
      text_hit <= lit;
`endif
    end
  end

endmodule

// File: tb/tb_text_layer.sv
// tb/tb_text_layer.sv - directed self-checking bench for text_layer
module tb_text_layer;

  localparam int COLS  = 28;
  localparam int ROWS  = 36;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [4:0] wr_col = '0;
  logic [5:0] wr_row = '0;
  logic [7:0] wr_char = '0;
  logic [2:0] wr_attr = '0;
  logic       clear = 1'b0;
  logic       busy;
  logic       frame_start = 1'b0;
  logic [7:0] sx = '0;
  logic [8:0] sy = '0;
  logic [3:0] R, G, B;
`ifdef TEXT_LAYER_HIT_EN
  logic       text_hit;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_char [CELLS];
  logic [2:0] m_attr [CELLS];
  bit         blink_vis = 1'b1;
  int         qx[$];
  int         qy[$];

  text_layer #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(30)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char), .wr_attr(wr_attr),
    .clear(clear), .busy(busy), .frame_start(frame_start), .sx(sx), .sy(sy),
    .R(R), .G(G), .B(B)
`ifdef TEXT_LAYER_HIT_EN
    , .text_hit(text_hit)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  function automatic logic [7:0] ref_font(input logic [7:0] ch, input int r);
    logic [63:0] g;
    case (ch)
      8'h23:   g = 64'h2424_7E24_7E24_2400;
      8'h41:   g = 64'h1824_4242_7E42_4200;
      8'h5A:   g = 64'h7E04_0810_2040_7E00;
      default: g = 64'h0;
    endcase
    return g[63 - 8 * r -: 8];
  endfunction

  function automatic logic [12:0] exp_pix(input int x, input int y);
    int idx;
    logic [7:0] row;
    logic [2:0] at;
    logic lit;
    if (x >= COLS * 8 || y >= ROWS * 8) return 13'h0;
    idx = (y / 8) * COLS + x / 8;
    at  = m_attr[idx];
    row = ref_font(m_char[idx], y % 8);
    lit = row[7 - x % 8] && !(at[2] && !blink_vis);
    if (!lit) return 13'h0;
    case (at[1:0])
      2'd0:    return 13'h1FFF;
      2'd1:    return 13'h1FF0;
      2'd2:    return 13'h1F00;
      default: return 13'h10FF;
    endcase
  endfunction

  task automatic model_blank();
    for (int i = 0; i < CELLS; i++) begin
      m_char[i] = 8'h20;
      m_attr[i] = 3'b000;
    end
  endtask

  task automatic add_region(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        qx.push_back(x);
        qy.push_back(y);
      end
  endtask

  task automatic add_cells(input int fine);
    for (int cy = 0; cy < ROWS; cy++)
      for (int cx = 0; cx < COLS; cx++) begin
        qx.push_back(cx * 8 + (cx + cy + fine) % 8);
        qy.push_back(cy * 8 + (cx + 3 * cy + fine) % 8);
      end
  endtask

  // Streams queued pixels one per cycle and compares each result two cycles later.
  task automatic run_scan(output int bad, output int bx, output int by,
                          output logic [12:0] bgot, output logic [12:0] bexp,
                          output logic [12:0] last);
    int n;
    logic [12:0] got, exp;
    n = qx.size();
    bad = 0; bx = -1; by = -1; bgot = '0; bexp = '0; last = '0;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        exp = exp_pix(qx[i - 2], qy[i - 2]);
`ifdef TEXT_LAYER_HIT_EN
        got = {text_hit, R, G, B};
`else
        got = {1'b0, R, G, B};
        exp[12] = 1'b0;
`endif
        last = got;
        if (got !== exp) begin
          if (bad == 0) begin
            bx = qx[i - 2]; by = qy[i - 2]; bgot = got; bexp = exp;
          end
          bad++;
        end
      end
      if (i < n) begin
        sx = 8'(qx[i]);
        sy = 9'(qy[i]);
      end
    end
    qx.delete();
    qy.delete();
  endtask

  task automatic do_write(input int col, input int row, input logic [7:0] ch,
                          input logic [2:0] at, output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_col = 5'(col); wr_row = 6'(row); wr_char = ch; wr_attr = at;
    while (wr_ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (wr_ready === 1'b1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    if (ok && col < COLS && row < ROWS) begin
      m_char[row * COLS + col] = ch;
      m_attr[row * COLS + col] = at;
    end
  endtask

  task automatic pulse_frames(input int n);
    repeat (n) begin
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    int cnt, bad, bx, by;
    logic [12:0] bg, be, last;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b want=1", busy); end
    checks++;
    if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b want=0", wr_ready); end
    checks++;
    if ({R, G, B} !== 12'h000) begin failures++; $display("FAIL reset_rgb got=%h want=000", {R, G, B}); end
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 1008) begin failures++; $display("FAIL reset_clear_cycles got=%0d want=1008", cnt); end
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL idle_wr_ready got=%b want=1", wr_ready); end
    model_blank();
    add_cells(0);
    add_region(0, 223, 0, 7);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL reset_blank_scan bad=%0d at (%0d,%0d) got=%h want=%h", bad, bx, by, bg, be); end
  endtask

  task automatic test_write_a();
    bit ok;
    int bad, bx, by;
    logic [12:0] bg, be, last;
    do_write(3, 2, 8'h41, 3'd1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL write_a_handshake got=0 want=1"); end
    @(negedge clk); sx = 8'd0; sy = 9'd0;
    repeat (3) @(negedge clk);
    sx = 8'd27; sy = 9'd16;
    @(negedge clk); sx = 8'd0; sy = 9'd0;
    checks++;
    if ({R, G, B} !== 12'h000) begin failures++; $display("FAIL latency_cycle1 got=%h want=000", {R, G, B}); end
    @(negedge clk);
    checks++;
    if ({R, G, B} !== 12'hFF0) begin failures++; $display("FAIL latency_cycle2 got=%h want=ff0", {R, G, B}); end
    @(negedge clk);
    checks++;
    if ({R, G, B} !== 12'h000) begin failures++; $display("FAIL latency_cycle3 got=%h want=000", {R, G, B}); end
    add_region(16, 39, 8, 31);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL write_a_scan bad=%0d at (%0d,%0d) got=%h want=%h", bad, bx, by, bg, be); end
  endtask

  task automatic test_blink();
    bit ok;
    int bad, bx, by;
    logic [12:0] bg, be, last;
    do_write(5, 5, 8'h41, 3'b100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL blink_write_handshake got=0 want=1"); end
    add_region(40, 47, 40, 47);
    add_region(41, 41, 44, 44);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (bad != 0 || last[11:0] !== 12'hFFF) begin failures++; $display("FAIL blink_initial bad=%0d last=%h want=fff", bad, last[11:0]); end
    pulse_frames(29);
    add_region(41, 41, 44, 44);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (last[11:0] !== 12'hFFF) begin failures++; $display("FAIL blink_after29 got=%h want=fff", last[11:0]); end
    pulse_frames(1);
    blink_vis = 1'b0;
    add_region(40, 47, 40, 47);
    add_region(24, 31, 16, 23);
    add_region(41, 41, 44, 44);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (bad != 0 || last[11:0] !== 12'h000) begin failures++; $display("FAIL blink_after30 bad=%0d at (%0d,%0d) last=%h want=000", bad, bx, by, last[11:0]); end
    pulse_frames(30);
    blink_vis = 1'b1;
    add_region(40, 47, 40, 47);
    add_region(41, 41, 44, 44);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (bad != 0 || last[11:0] !== 12'hFFF) begin failures++; $display("FAIL blink_after60 bad=%0d last=%h want=fff", bad, last[11:0]); end
  endtask

  task automatic test_clear_collision();
    bit ok;
    int cnt, bad, bx, by;
    logic [12:0] bg, be, last;
    do_write(0, 0, 8'h23, 3'd2, ok);
    add_region(0, 7, 0, 7);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (!ok || bad != 0) begin failures++; $display("FAIL hash_before_clear ok=%0d bad=%0d got=%h want=%h", ok, bad, bg, be); end
    @(negedge clk);
    clear = 1'b1; wr_valid = 1'b1; wr_col = 5'd0; wr_row = 6'd0; wr_char = 8'h5A; wr_attr = 3'd3;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin failures++; $display("FAIL clear_vs_write_ready got=%b want=0", wr_ready); end
    @(negedge clk);
    clear = 1'b0; wr_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy_next got=%b want=1", busy); end
    checks++;
    if (wr_ready !== 1'b0) begin failures++; $display("FAIL clearing_wr_ready got=%b want=0", wr_ready); end
    cnt = 0;
    while (busy === 1'b1 && cnt < 3000) begin
      cnt++;
      clear = (cnt == 500);
      @(negedge clk);
    end
    clear = 1'b0;
    checks++;
    if (cnt != 1008) begin failures++; $display("FAIL clear_cycles_no_restart got=%0d want=1008", cnt); end
    model_blank();
    add_region(0, 7, 0, 7);
    add_region(24, 31, 16, 23);
    add_region(40, 47, 40, 47);
    add_cells(1);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL after_clear_scan bad=%0d at (%0d,%0d) got=%h want=%h", bad, bx, by, bg, be); end
  endtask

  task automatic test_out_of_range();
    bit ok;
    int bad, bx, by;
    logic [12:0] bg, be, last;
    do_write(28, 0, 8'h23, 3'd0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL oor_handshake got=0 want=1"); end
    add_region(0, 223, 0, 15);
    for (int f = 0; f < 8; f++) add_cells(f);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL oor_scan_unchanged bad=%0d at (%0d,%0d) got=%h want=%h", bad, bx, by, bg, be); end
    do_write(27, 0, 8'h5A, 3'd2, ok);
    add_region(208, 223, 0, 15);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (!ok || bad != 0) begin failures++; $display("FAIL write_after_oor ok=%0d bad=%0d at (%0d,%0d) got=%h want=%h", ok, bad, bx, by, bg, be); end
  endtask

  task automatic test_back_to_back();
    int stalls, bad, bx, by;
    logic [12:0] bg, be, last;
    stalls = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    for (int i = 0; i < CELLS; i++) begin
      wr_col = 5'(i % COLS); wr_row = 6'(i / COLS); wr_char = 8'h23; wr_attr = 3'd3;
      m_char[i] = 8'h23; m_attr[i] = 3'd3;
      #1;
      if (wr_ready !== 1'b1) stalls++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    checks++;
    if (stalls != 0) begin failures++; $display("FAIL b2b_stalls got=%0d want=0", stalls); end
    add_region(216, 255, 0, 15);
    add_region(0, 15, 280, 300);
    add_region(250, 255, 505, 511);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (bad != 0) begin failures++; $display("FAIL edge_scan bad=%0d at (%0d,%0d) got=%h want=%h", bad, bx, by, bg, be); end
    add_region(218, 218, 0, 0);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (last[11:0] !== 12'h0FF) begin failures++; $display("FAIL last_col_lit got=%h want=0ff", last[11:0]); end
    add_region(226, 226, 0, 0);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (last !== 13'h0) begin failures++; $display("FAIL sx224_area got=%h want=0000", last); end
    add_region(2, 2, 288, 288);
    run_scan(bad, bx, by, bg, be, last);
    checks++;
    if (last !== 13'h0) begin failures++; $display("FAIL sy288_area got=%h want=0000", last); end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_blink();
    test_clear_collision();
    test_out_of_range();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
